// File: rtl/neuron_step_scheduler.sv
// Time-multiplexes one combinational neuron-update datapath across N neurons.
// Each start pulse sweeps every index once, applies threshold/reset and streams spikes.
module neuron_step_scheduler #(
    parameter int N     = 16,
    parameter int IDX_W = 4,
    parameter int W     = 16,
    parameter logic signed [W-1:0] V_THRESH = 16'sd8192,
    parameter logic signed [W-1:0] V_RESET  = 16'sd0,
    parameter logic signed [W-1:0] W_JUMP   = 16'sd410
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [W-1:0]     i_wr_data,
    output logic             upd_en,
    output logic [W-1:0]     upd_v,
    output logic [W-1:0]     upd_w,
    output logic [W-1:0]     upd_i,
    input  logic [W-1:0]     upd_v_next,
    input  logic [W-1:0]     upd_w_next,
    output logic             spike_valid,
    input  logic             spike_ready,
    output logic [IDX_W-1:0] spike_idx,
    output logic [15:0]      spike_step,
    output logic [15:0]      step_count
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CALC = 3'd1;
    localparam logic [2:0] ST_WB   = 3'd2;
    localparam logic [2:0] ST_EMIT = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    logic [2:0]              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [W-1:0]     nv_q, nv_d;
    logic signed [W-1:0]     nw_q, nw_d;
    logic [IDX_W-1:0]        spike_idx_q, spike_idx_d;
    logic [15:0]             spike_step_q, spike_step_d;
    logic [15:0]             step_count_q, step_count_d;
    logic                    busy_q, done_q, upd_en_q, spike_valid_q;

    logic signed [W-1:0]     v_mem_q [N];
    logic signed [W-1:0]     w_mem_q [N];
    logic signed [W-1:0]     i_mem_q [N];

    logic signed [W-1:0]     rd_v_s, rd_w_s, rd_i_s;
    logic                    wb_we_s;
    logic signed [W-1:0]     wb_v_s, wb_w_s;
    logic                    last_s;
    logic                    spike_s;

    // Two's-complement add clamped to the representable range on overflow.
    function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
        logic [W:0] sum;
        sum = {a[W-1], a} + {b[W-1], b};
        if (sum[W] != sum[W-1]) begin
            if (sum[W]) begin
                return {1'b1, {(W-1){1'b0}}};
            end else begin
                return {1'b0, {(W-1){1'b1}}};
            end
        end else begin
            return sum[W-1:0];
        end
    endfunction

    assign last_s  = (idx_q == LAST_IDX);
    assign spike_s = (nv_q >= V_THRESH);

    // Read mux: state of the current index, presented to the datapath in CALC.
    always_comb begin
        rd_v_s = '0;
        rd_w_s = '0;
        rd_i_s = '0;
        for (int k = 0; k < N; k++) begin
            if (idx_q == IDX_W'(k)) begin
                rd_v_s = v_mem_q[k];
                rd_w_s = w_mem_q[k];
                rd_i_s = i_mem_q[k];
            end else begin
                rd_v_s = rd_v_s;
                rd_w_s = rd_w_s;
                rd_i_s = rd_i_s;
            end
        end
    end

    // Sweep sequencing, threshold decision and write-back value selection.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        nv_d         = nv_q;
        nw_d         = nw_q;
        spike_idx_d  = spike_idx_q;
        spike_step_d = spike_step_q;
        step_count_d = step_count_q;
        wb_we_s      = 1'b0;
        wb_v_s       = nv_q;
        wb_w_s       = nw_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CALC;
                    idx_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                nv_d    = upd_v_next;
                nw_d    = upd_w_next;
                state_d = ST_WB;
            end
            ST_WB: begin
                wb_we_s = 1'b1;
                if (spike_s) begin
                    wb_v_s       = V_RESET;
                    wb_w_s       = sat_add(nw_q, W_JUMP);
                    spike_idx_d  = idx_q;
                    spike_step_d = step_count_q;
                    state_d      = ST_EMIT;
                end else if (last_s) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_CALC;
                end
            end
            ST_EMIT: begin
                if (spike_ready && last_s) begin
                    state_d = ST_DONE;
                end else if (spike_ready) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_DONE: begin
                step_count_d = step_count_q + 16'd1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; status outputs are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            nv_q          <= '0;
            nw_q          <= '0;
            spike_idx_q   <= '0;
            spike_step_q  <= 16'd0;
            step_count_q  <= 16'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            upd_en_q      <= 1'b0;
            spike_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            nv_q          <= nv_d;
            nw_q          <= nw_d;
            spike_idx_q   <= spike_idx_d;
            spike_step_q  <= spike_step_d;
            step_count_q  <= step_count_d;
            busy_q        <= (state_d != ST_IDLE);
            done_q        <= (state_d == ST_DONE);
            upd_en_q      <= (state_d == ST_CALC);
            spike_valid_q <= (state_d == ST_EMIT);
        end
    end

    // State banks; an input-current write in CALC lands after the read, so the old value is used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                v_mem_q[k] <= '0;
                w_mem_q[k] <= '0;
                i_mem_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (wb_we_s && (idx_q == IDX_W'(k))) begin
                    v_mem_q[k] <= wb_v_s;
                    w_mem_q[k] <= wb_w_s;
                end
                if (i_wr_en && (i_wr_idx == IDX_W'(k))) begin
                    i_mem_q[k] <= i_wr_data;
                end
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign upd_en      = upd_en_q;
    assign upd_v       = rd_v_s;
    assign upd_w       = rd_w_s;
    assign upd_i       = rd_i_s;
    assign spike_valid = spike_valid_q;
    assign spike_idx   = spike_idx_q;
    assign spike_step  = spike_step_q;
    assign step_count  = step_count_q;

endmodule

// File: tb/tb_neuron_step_scheduler.sv
// Scoreboard bench for neuron_step_scheduler: a sweep-level reference model predicts
// datapath presentations, spikes and done pulses; a negedge monitor compares them.
module tb_neuron_step_scheduler;

    localparam int N     = 4;
    localparam int IDX_W = 3;
    localparam int W     = 16;
    localparam logic signed [15:0] TH = 16'sd8192;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start, i_wr_en, spike_ready;
    logic [IDX_W-1:0] i_wr_idx;
    logic [W-1:0] i_wr_data;
    logic busy, done, upd_en, spike_valid;
    logic [W-1:0] upd_v, upd_w, upd_i, upd_v_next, upd_w_next;
    logic [IDX_W-1:0] spike_idx;
    logic [15:0] spike_step, step_count;

    int checks = 0;
    int errors = 0;

    logic wfix = 1'b0;
    logic signed [15:0] wdelta = 16'sd0;

    // Bench-side datapath: v' = v + i, w' = w + delta (or a fixed value).
    assign upd_v_next = upd_v + upd_i;
    assign upd_w_next = wfix ? 16'sd32700 : upd_w + wdelta;

    always #5 clk = ~clk;

    neuron_step_scheduler #(.N(N), .IDX_W(IDX_W), .W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .i_wr_en(i_wr_en), .i_wr_idx(i_wr_idx), .i_wr_data(i_wr_data),
        .upd_en(upd_en), .upd_v(upd_v), .upd_w(upd_w), .upd_i(upd_i),
        .upd_v_next(upd_v_next), .upd_w_next(upd_w_next),
        .spike_valid(spike_valid), .spike_ready(spike_ready),
        .spike_idx(spike_idx), .spike_step(spike_step), .step_count(step_count)
    );

    typedef struct { logic [15:0] v; logic [15:0] w; logic [15:0] i; } calc_t;
    typedef struct { int idx; int step; } spk_t;

    logic signed [15:0] mv [N];
    logic signed [15:0] mw [N];
    logic signed [15:0] mi [N];
    int mstep;
    calc_t calc_q[$];
    spk_t  spk_q[$];
    int    done_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            mv[k] = 16'sd0;
            mw[k] = 16'sd0;
            mi[k] = 16'sd0;
        end
        mstep = 0;
        calc_q.delete();
        spk_q.delete();
        done_q.delete();
    endfunction

    // One whole timestep: returns number of spikes and queues expected observations.
    function automatic int predict();
        int nspk = 0;
        int s;
        logic signed [15:0] nv, nw;
        for (int k = 0; k < N; k++) begin
            calc_q.push_back(calc_t'{mv[k], mw[k], mi[k]});
            nv = mv[k] + mi[k];
            nw = wfix ? 16'sd32700 : mw[k] + wdelta;
            if (nv >= TH) begin
                s = int'(nw) + 410;
                if (s > 32767) s = 32767;
                mv[k] = 16'sd0;
                mw[k] = 16'(s);
                spk_q.push_back(spk_t'{k, mstep});
                nspk++;
            end else begin
                mv[k] = nv;
                mw[k] = nw;
            end
        end
        done_q.push_back(mstep);
        mstep = (mstep + 1) % 65536;
        return nspk;
    endfunction

    logic hold_pend = 1'b0;
    logic [IDX_W-1:0] hold_idx;
    logic [15:0] hold_step;

    // Monitor: pops expectations whenever the DUT presents CALC, a spike handshake or done.
    always @(negedge clk) begin
        calc_t c;
        spk_t  e;
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (upd_en) begin
                if (calc_q.size() == 0) begin
                    chk("calc_unexpected", 1, 0);
                end else begin
                    c = calc_q.pop_front();
                    chk("upd_v", upd_v, c.v);
                    chk("upd_w", upd_w, c.w);
                    chk("upd_i", upd_i, c.i);
                end
            end
            if (spike_valid) begin
                if (hold_pend) begin
                    chk("hold_idx", spike_idx, hold_idx);
                    chk("hold_step", spike_step, hold_step);
                    chk("hold_no_calc", upd_en, 0);
                end
                if (spike_ready) begin
                    hold_pend = 1'b0;
                    if (spk_q.size() == 0) begin
                        chk("spike_unexpected", 1, 0);
                    end else begin
                        e = spk_q.pop_front();
                        chk("spike_idx", spike_idx, e.idx);
                        chk("spike_step", spike_step, e.step);
                    end
                end else begin
                    hold_pend = 1'b1;
                    hold_idx  = spike_idx;
                    hold_step = spike_step;
                end
            end else begin
                hold_pend = 1'b0;
            end
            if (done) begin
                chk("done_excl_spike", spike_valid, 0);
                if (done_q.size() == 0) chk("done_unexpected", 1, 0);
                else chk("done_step", step_count, done_q.pop_front());
            end
        end
    end

    task automatic wr(input int idx, input int data);
        i_wr_en   = 1'b1;
        i_wr_idx  = IDX_W'(idx);
        i_wr_data = 16'(data);
        @(posedge clk); #1;
        i_wr_en = 1'b0;
        if (idx < N) mi[idx] = 16'(data);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_upd_en"}, upd_en, 0);
        chk({tag, "_spike_valid"}, spike_valid, 0);
        chk({tag, "_spike_idx"}, spike_idx, 0);
        chk({tag, "_spike_step"}, spike_step, 0);
        chk({tag, "_step_count"}, step_count, 0);
    endtask

    // stall_mode: 0 always ready, 1 hold ready low 5 cycles on first spike, 2 random ready.
    task automatic sweep(input int stall_mode, input bit hold_start, input bit race, output int lat);
        int nspk, stalls, n, ncalc, stall_left;
        bit seen;
        nspk = predict();
        stalls = 0; n = 0; ncalc = 0; stall_left = 5; seen = 1'b0;
        spike_ready = (stall_mode == 0);
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        chk("busy_rise", busy, 1);
        while (!seen && n < 400) begin
            i_wr_en = 1'b0;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (upd_en) begin
                    ncalc++;
                    if (race && ncalc == 2) begin
                        i_wr_en = 1'b1; i_wr_idx = IDX_W'(1); i_wr_data = 16'sd50;
                        mi[1] = 16'sd50;
                    end
                end
                if (spike_valid) begin
                    if (stall_mode == 1 && stall_left > 0) begin
                        spike_ready = 1'b0; stall_left--; stalls++;
                    end else if (stall_mode == 2) begin
                        spike_ready = 1'($urandom_range(0, 1));
                        if (!spike_ready) stalls++;
                    end else begin
                        spike_ready = 1'b1;
                    end
                end
                @(posedge clk); #1;
                n++;
            end
        end
        lat = n;
        if (!seen) chk("done_timeout", 0, 1);
        else chk("latency", n, 2 * N + nspk + stalls);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_fall", busy, 0);
        chk("step_count", step_count, mstep);
        spike_ready = 1'b1;
    endtask

    task automatic rst_in_emit();
        int n = 0;
        void'(predict());
        spike_ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!spike_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("emit_reached", spike_valid, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_zero("rst_emit");
        model_reset();
        @(negedge clk); #1;
        rst = 1'b0;
        spike_ready = 1'b1;
    endtask

    initial begin
        int lat;
        start = 1'b0; i_wr_en = 1'b0; i_wr_idx = '0; i_wr_data = '0; spike_ready = 1'b1;
        #1 rst = 1'b1;
        #1 check_zero("reset");
        #10 rst = 1'b0;
        model_reset();
        @(posedge clk); #1;

        // Plain sweeps; write to index 5 is out of range and must be dropped.
        wr(0, 100); wr(1, 200); wr(2, 300); wr(3, 400); wr(5, 7777);
        sweep(0, 1'b0, 1'b0, lat);
        chk("plain_latency", lat, 2 * N);
        sweep(0, 1'b0, 1'b0, lat);

        // start held high throughout: exactly one sweep.
        sweep(0, 1'b1, 1'b0, lat);

        // Write race on index 1 during its CALC cycle.
        sweep(0, 1'b0, 1'b1, lat);
        sweep(0, 1'b0, 1'b0, lat);

        wr(2, 8192);
        rst_in_emit();

        // Spike with recovery saturation, then observe the reset/saturated state.
        wr(2, 8192);
        wfix = 1'b1;
        sweep(0, 1'b0, 1'b0, lat);
        sweep(0, 1'b0, 1'b0, lat);

        // Backpressure: ready low 5 cycles on the single spike.
        sweep(1, 1'b0, 1'b0, lat);
        chk("bp_latency", lat, 2 * N + 6);

        wfix = 1'b0;
        repeat (25) begin
            repeat ($urandom_range(0, 3)) wr(int'($urandom_range(0, N)), int'($urandom_range(0, 4000)) - 500);
            wdelta = 16'(int'($urandom_range(0, 200)) - 100);
            sweep(2, 1'b0, 1'b0, lat);
        end

        chk("queues_empty", calc_q.size() + spk_q.size() + done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/neuron_step_scheduler.md
# neuron_step_scheduler

Time-multiplexes one shared neuron-update datapath across `N` neurons. It holds the per-neuron membrane (`v`), recovery (`w`) and input-current (`i`) state in register banks. On each `start` pulse it sweeps every neuron index once: it presents the neuron's state to the datapath, captures the next state and applies threshold/reset. Spike events are reported on a valid/ready stream. The block sits between the host/input loader and the single combinational update unit.

## Interface
- `N`, 16, number of neurons (≥2)
- `IDX_W`, 4, index width, ≥ clog2(N)
- `W`, 16, state width, signed Q3.12
- `V_THRESH`, 16'sd8192, spike threshold (2.0)
- `V_RESET`, 16'sd0, post-spike membrane value
- `W_JUMP`, 16'sd410, post-spike recovery increment (~0.1)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin one timestep sweep; accepted only in IDLE
- `busy`  out  1  sweep in progress (CALC/WB/EMIT/DONE)
- `done`  out  1  one-cycle pulse, sweep complete
- `i_wr_en`, `i_wr_idx[IDX_W]`, `i_wr_data[W]`  in  input-current write port
- `upd_en`  out  1  high in CALC
- `upd_v`, `upd_w`, `upd_i`  out  W  state of current index, to datapath
- `upd_v_next`, `upd_w_next`  in  W  datapath result, combinational, same cycle
- `spike_valid`  out  1  spike event pending
- `spike_ready`  in  1  consumer accepts
- `spike_idx`  out  IDX_W  spiking neuron index
- `spike_step`  out  16  step_count at time of spike
- `step_count`  out  16  completed sweeps, wraps 0xFFFF→0

## Operation
- FSM states: IDLE, CALC, WB, EMIT, DONE.
- IDLE: on `start`, set idx=0 and go to CALC. `start` outside IDLE is ignored, not queued.
- CALC: `upd_v/w/i` = `v_mem/w_mem/i_mem[idx]` combinationally, with `upd_en`=1. At the clock edge, latch `upd_v_next`, `upd_w_next` into `nv`, `nw`, then go to WB.
- WB, spike case (`nv` ≥ `V_THRESH`, signed compare):
  - `v_mem[idx]` ← `V_RESET`.
  - `w_mem[idx]` ← `nw` + `W_JUMP`, saturated to [−32768, 32767].
  - Load `spike_idx`=idx and `spike_step`=step_count, then go to EMIT.
- WB, no-spike case: `v_mem[idx]` ← `nv`, `w_mem[idx]` ← `nw`. Go to CALC with idx+1, or to DONE if idx==N−1.
- EMIT: hold `spike_valid`=1 with `spike_idx`/`spike_step` stable. On `spike_valid && spike_ready`, go to the next CALC (idx+1) or to DONE if idx==N−1.
- DONE: `done`=1 for one cycle; step_count+1 at the exit edge; go to IDLE.
- `i_wr_en` is accepted in any state; `i_mem[i_wr_idx]` ← `i_wr_data` at the edge.
  - A write to the index in CALC during that same cycle is not seen this sweep; the old value is used.
  - `i_wr_idx` ≥ N is ignored.
- The `i_mem` value persists across sweeps; it is not auto-cleared.
- `upd_*` outputs are don't-care outside CALC. The bench checks them only when `upd_en`=1.

## Timing
- Reset (async, immediate):
  - State → IDLE; idx=0.
  - All `v_mem`, `w_mem`, `i_mem` = 0.
  - `busy`, `done`, `upd_en`, `spike_valid` = 0; `spike_idx`, `spike_step`, `step_count` = 0.
- `start` high at edge E0 → CALC idx0 during cycle after E0, and `busy`=1 from E0.
- No spikes: 2 cycles per neuron. `done`=1 in the cycle after edge E(2N); `busy` falls at E(2N+1).
  - The earliest new `start` is sampled at E(2N+1), returning the FSM to IDLE; it is accepted at the following edge.
- Each spike adds one EMIT cycle plus any cycles `spike_ready` is held low.
- Spike on idx N−1: EMIT precedes DONE; `done` never overlaps `spike_valid`.
- `rst` mid-sweep: the partial sweep is abandoned and all state is cleared. `done` does not pulse and `step_count` stays 0.

## Test plan
- **Reset:** assert `rst` mid-EMIT → all outputs 0 immediately; `spike_valid` drops without handshake; `v_mem` reads back 0 on the next sweep.
- **Plain sweep:**
  - Setup: N=4; bench datapath `v_next`=v+i, `w_next`=w; i={16'sd100, 200, 300, 400}.
  - Stimulus: `start`.
  - Response: `done` in cycle 9 after the start edge, no spikes, `step_count`=1; second sweep shows `upd_v`={100,200,300,400}.
- **Spike + saturation:**
  - Setup: i[2]=16'sd8192; bench `w_next`=16'sd32700.
  - Response: `spike_idx`=2, `spike_step`=0; next sweep shows `upd_v`=0 and `upd_w`=32767 for idx2.
- **Backpressure:** a spike with `spike_ready` low for 5 cycles → `spike_valid` and `spike_idx` held stable; no CALC advance; `done` delayed by 6 cycles versus no-spike timing.
- **Ignored `start`:** `start` pulsed every cycle during a sweep → exactly one sweep; `step_count` increments by 1 per IDLE-accepted `start` only.
- **Write race:** `i_wr_en` to idx1 during idx1's CALC cycle with value 16'sd50 → this sweep uses the old i; the next sweep `upd_i`=50.
